// File: rtl/task_scheduler.sv
// task_scheduler
//   Priority scheduler for the task modules on the shared 16-bit op bus.
//   It samples every task's sorter word and picks the highest-priority ready
//   task, using round-robin order to break ties. It then issues Execute,
//   times a fixed slice and issues Finish execution. Between slices it
//   forwards host op words onto the same bus. Tasks that keep losing
//   arbitration are promoted through Increase-priority ops.
//
// Ports
//   CLK            system clock
//   RST_N          asynchronous active-low reset
//   enable         scheduling allowed; when low, the current slice completes
//                  and the scheduler then parks in IDLE
//   sorter_bus     NUM_TASKS x 8-bit slots: [7:4] task id, [3:0] priority;
//                  an all-zero slot means the task is not ready
//   host_op        host op word, same encoding as op_out
//   host_valid     host_op pending
//   host_ready     one-cycle pulse, high while host_op is driven on op_out
//   op_out         {4'h0, target id, opcode, argument}; 16'h0000 = no op
//   cur_task       id of the task in (or last in) slice
//   busy           high from DISPATCH through FINISH
//   dispatch_count number of Execute ops issued (wraps)
//
// SLICE_CYCLES must be at least 2. AGE_LIMIT is meaningful in 1..7.
module task_scheduler #(
  parameter int NUM_TASKS    = 8,
  parameter int SLICE_CYCLES = 10000,
  parameter int AGE_LIMIT    = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   enable,
  input  logic [NUM_TASKS*8-1:0] sorter_bus,
  input  logic [15:0]            host_op,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [15:0]            op_out,
  output logic [3:0]             cur_task,
  output logic                   busy,
  output logic [31:0]            dispatch_count
);

  typedef enum logic [2:0] {
    IDLE, HOST, SCAN, AGE, DISPATCH, RUN, FINISH
  } state_t;

  localparam logic [3:0]  OP_EXEC   = 4'b0111;
  localparam logic [3:0]  OP_FINISH = 4'b1111;
  localparam logic [3:0]  OP_BUMP   = 4'b0101;
  // RUN lasts SLICE_CYCLES-1 cycles; the counter starts at 0.
  localparam logic [31:0] RUN_LAST  = 32'(SLICE_CYCLES - 2);

  function automatic logic [2:0] sat_age(input logic [2:0] a);
    return (a == 3'd7) ? a : a + 3'd1;
  endfunction

  function automatic logic [3:0] sat_prio(input logic [3:0] p);
    return (p == 4'hF) ? p : p + 4'h1;
  endfunction

  state_t      state;
  logic [3:0]  rr_ptr;
  logic [3:0]  win_idx;
  logic [3:0]  win_id;
  logic [31:0] slice_cnt;
  logic [2:0]  age [NUM_TASKS];

  logic                 scan_hit;
  logic [3:0]           scan_idx;
  logic [3:0]           scan_id;
  logic [NUM_TASKS-1:0] loser;
  logic [2:0]           age_inc [NUM_TASKS];
  logic                 bump_hit;
  logic [3:0]           bump_idx;
  logic [15:0]          bump_op;
  logic                 win_slot_zero;
  logic                 go_disp;
  logic [3:0]           disp_idx;
  logic [3:0]           disp_id;

  // Arbitration: walk the slots starting at rr_ptr; only a strictly higher
  // priority displaces the current best, so ties resolve to the first slot
  // met in round-robin order.
  always_comb begin
    int         idx;
    logic [7:0] slot;
    logic [3:0] best_prio;
    idx       = 0;
    slot      = '0;
    best_prio = '0;
    scan_hit  = 1'b0;
    scan_idx  = '0;
    scan_id   = '0;
    for (int k = 0; k < NUM_TASKS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_TASKS) idx = idx - NUM_TASKS;
      slot = sorter_bus[idx*8 +: 8];
      if (slot != 8'h00 && (!scan_hit || slot[3:0] > best_prio)) begin
        scan_hit  = 1'b1;
        scan_idx  = 4'(idx);
        scan_id   = slot[7:4];
        best_prio = slot[3:0];
      end
    end
  end

  // Starvation tracking: ready losers age by one; the lowest-index loser
  // whose new age reaches the limit is promoted.
  always_comb begin
    bump_hit      = 1'b0;
    bump_idx      = '0;
    bump_op       = '0;
    loser         = '0;
    win_slot_zero = 1'b0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      age_inc[i] = sat_age(age[i]);
      loser[i]   = (sorter_bus[i*8 +: 8] != 8'h00) && (4'(i) != scan_idx);
      if (!bump_hit && loser[i] && int'(age_inc[i]) >= AGE_LIMIT) begin
        bump_hit = 1'b1;
        bump_idx = 4'(i);
        bump_op  = {4'h0, sorter_bus[i*8+4 +: 4], OP_BUMP,
                    sat_prio(sorter_bus[i*8 +: 4])};
      end
      if (4'(i) == win_idx) win_slot_zero = (sorter_bus[i*8 +: 8] == 8'h00);
    end
  end

  // DISPATCH is entered either straight from SCAN or after an AGE cycle;
  // in the latter case the winner comes from the latched copy.
  always_comb begin
    go_disp  = (state == SCAN && scan_hit && !bump_hit) || (state == AGE);
    disp_idx = (state == AGE) ? win_idx : scan_idx;
    disp_id  = (state == AGE) ? win_id  : scan_id;
  end

  // Outputs are registered and loaded on the transition into the state
  // that owns them, so each op sits on op_out exactly during that state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      op_out         <= '0;
      host_ready     <= 1'b0;
      cur_task       <= '0;
      busy           <= 1'b0;
      dispatch_count <= '0;
      rr_ptr         <= '0;
      win_idx        <= '0;
      win_id         <= '0;
      slice_cnt      <= '0;
      for (int i = 0; i < NUM_TASKS; i++) age[i] <= '0;
    end else begin
      op_out     <= '0;
      host_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (host_valid) begin
            op_out     <= host_op;
            host_ready <= 1'b1;
            state      <= HOST;
          end else if (enable) begin
            state <= SCAN;
          end
        end
        HOST: state <= enable ? SCAN : IDLE;
        SCAN: begin
          if (!scan_hit) begin
            state <= IDLE;
          end else begin
            win_idx <= scan_idx;
            win_id  <= scan_id;
            for (int i = 0; i < NUM_TASKS; i++) begin
              if (loser[i])
                age[i] <= (bump_hit && 4'(i) == bump_idx) ? 3'd0 : age_inc[i];
            end
            if (bump_hit) begin
              op_out <= bump_op;
              state  <= AGE;
            end
          end
        end
        AGE: ;
        DISPATCH: begin
          slice_cnt <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (win_slot_zero || slice_cnt == RUN_LAST) begin
            op_out <= {4'h0, win_id, OP_FINISH, 4'h0};
            state  <= FINISH;
          end else begin
            slice_cnt <= slice_cnt + 32'd1;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          if (host_valid) begin
            op_out     <= host_op;
            host_ready <= 1'b1;
            state      <= HOST;
          end else if (enable) begin
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (go_disp) begin
        op_out         <= {4'h0, disp_id, OP_EXEC, 4'h0};
        cur_task       <= disp_id;
        busy           <= 1'b1;
        dispatch_count <= dispatch_count + 32'd1;
        rr_ptr         <= (disp_idx == 4'(NUM_TASKS - 1)) ? 4'd0 : disp_idx + 4'd1;
        for (int i = 0; i < NUM_TASKS; i++) begin
          if (4'(i) == disp_idx) age[i] <= '0;
        end
        state <= DISPATCH;
      end
    end
  end

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler: 4 slots, 8-cycle slice, age limit 2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_task_scheduler;

  localparam int NT = 4;
  localparam int SC = 8;
  localparam int AL = 2;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           enable = 1'b0;
  logic [NT*8-1:0] sorter_bus = '0;
  logic [15:0]    host_op = '0;
  logic           host_valid = 1'b0;
  logic           host_ready;
  logic [15:0]    op_out;
  logic [3:0]     cur_task;
  logic           busy;
  logic [31:0]    dispatch_count;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  task_scheduler #(
    .NUM_TASKS   (NT),
    .SLICE_CYCLES(SC),
    .AGE_LIMIT   (AL)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .enable        (enable),
    .sorter_bus    (sorter_bus),
    .host_op       (host_op),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .op_out        (op_out),
    .cur_task      (cur_task),
    .busy          (busy),
    .dispatch_count(dispatch_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // Reset values
    step(3);
    chk("rst_op", 32'(op_out), 32'h0);
    chk("rst_hready", 32'(host_ready), 32'h0);
    chk("rst_cur", 32'(cur_task), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dcount", dispatch_count, 32'h0);

    // Single task 0x83: Execute two cycles after enable, Finish 8 later
    RST_N = 1'b1;
    sorter_bus = 32'h0000_0083;
    enable = 1'b1;
    step(1);
    chk("t1_scan_op", 32'(op_out), 32'h0);
    step(1);
    chk("t1_exec", 32'(op_out), 32'h0870);
    chk("t1_cur", 32'(cur_task), 32'h8);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_dcount", dispatch_count, 32'd1);
    step(7);
    chk("t1_run_op", 32'(op_out), 32'h0);
    chk("t1_run_busy", 32'(busy), 32'h1);
    step(1);
    chk("t1_finish", 32'(op_out), 32'h08F0);
    enable = 1'b0;
    step(1);
    chk("t1_idle_op", 32'(op_out), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_dcount2", dispatch_count, 32'd1);

    // Priority + round-robin ties: slots 0x82, 0x95, 0xA5
    RST_N = 1'b0;
    step(2);
    RST_N = 1'b1;
    sorter_bus = 32'h00A5_9582;
    enable = 1'b1;
    step(2);
    chk("t2_exec9", 32'(op_out), 32'h0970);
    step(8);
    chk("t2_fin9", 32'(op_out), 32'h09F0);
    step(2);
    chk("t2_bump8", 32'(op_out), 32'h0853);
    step(1);
    chk("t2_execA", 32'(op_out), 32'h0A70);
    step(8);
    chk("t2_finA", 32'(op_out), 32'h0AF0);
    step(2);
    chk("t2_exec9b", 32'(op_out), 32'h0970);
    chk("t2_dcount", dispatch_count, 32'd3);

    // Host op raised during RUN is held until after FINISH
    host_op = 16'h0851;
    host_valid = 1'b1;
    step(4);
    chk("t3_run_op", 32'(op_out), 32'h0);
    chk("t3_run_hready", 32'(host_ready), 32'h0);
    step(4);
    chk("t3_fin9", 32'(op_out), 32'h09F0);
    chk("t3_fin_hready", 32'(host_ready), 32'h0);
    step(1);
    chk("t3_host_op", 32'(op_out), 32'h0851);
    chk("t3_host_ready", 32'(host_ready), 32'h1);
    host_valid = 1'b0;
    host_op = 16'h0;
    step(1);
    chk("t3_scan_op", 32'(op_out), 32'h0);
    chk("t3_scan_hready", 32'(host_ready), 32'h0);
    chk("t3_scan_busy", 32'(busy), 32'h0);
    step(1);
    chk("t3_bump8", 32'(op_out), 32'h0853);
    step(1);
    chk("t3_execA", 32'(op_out), 32'h0A70);
    chk("t3_curA", 32'(cur_task), 32'hA);

    // Winner leaves Ready mid-RUN: Finish the next cycle, then rescan
    step(2);
    sorter_bus = 32'h0000_9582;
    step(1);
    chk("t4_early_fin", 32'(op_out), 32'h0AF0);
    step(1);
    chk("t4_scan_op", 32'(op_out), 32'h0);
    chk("t4_scan_busy", 32'(busy), 32'h0);
    step(1);
    chk("t4_exec9", 32'(op_out), 32'h0970);

    // Reset mid-RUN: outputs clear at once, no Finish appears
    step(2);
    RST_N = 1'b0;
    #1;
    chk("t5_rst_op", 32'(op_out), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_cur", 32'(cur_task), 32'h0);
    chk("t5_rst_dcount", dispatch_count, 32'h0);
    step(3);
    chk("t5_rst_hold", 32'(op_out), 32'h0);

    // Aging: 0x81 loses twice to 0x95, then gets bumped to priority 2
    RST_N = 1'b1;
    sorter_bus = 32'h0000_9581;
    enable = 1'b1;
    step(2);
    chk("t6_exec9", 32'(op_out), 32'h0970);
    step(8);
    chk("t6_fin9", 32'(op_out), 32'h09F0);
    step(1);
    chk("t6_scan_op", 32'(op_out), 32'h0);
    step(1);
    chk("t6_bump8", 32'(op_out), 32'h0852);
    step(1);
    chk("t6_exec9b", 32'(op_out), 32'h0970);
    chk("t6_dcount", dispatch_count, 32'd2);

    // enable dropped mid-RUN: slice completes, then IDLE; host op from IDLE
    enable = 1'b0;
    step(8);
    chk("t7_fin9", 32'(op_out), 32'h09F0);
    chk("t7_fin_busy", 32'(busy), 32'h1);
    step(1);
    chk("t7_idle_op", 32'(op_out), 32'h0);
    chk("t7_idle_busy", 32'(busy), 32'h0);
    host_op = 16'h0C51;
    host_valid = 1'b1;
    step(1);
    chk("t7_host_op", 32'(op_out), 32'h0C51);
    chk("t7_host_ready", 32'(host_ready), 32'h1);
    host_valid = 1'b0;
    step(1);
    chk("t7_after_op", 32'(op_out), 32'h0);
    chk("t7_after_hready", 32'(host_ready), 32'h0);
    chk("t7_after_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
